// File: rtl/gpio_cmd_pkg.sv
// Shared types and constants for the GPIO command arbiter: command opcodes,
// register selects, FSM state encoding and the GPIO register offset map.
package gpio_cmd_pkg;

  typedef enum logic [2:0] {
    OP_WRITE = 3'd0,
    OP_READ  = 3'd1,
    OP_OR    = 3'd2,
    OP_AND   = 3'd3,
    OP_XOR   = 3'd4
  } op_e;

  typedef enum logic [1:0] {
    SEL_DATA  = 2'd0,
    SEL_OUT   = 2'd1,
    SEL_DIR   = 2'd2,
    SEL_IMASK = 2'd3
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Width of a requester index (up to 8 requesters).
  localparam int ID_W = 3;

  // Plain register offsets.
  localparam logic [31:0] OFF_DATA  = 32'h00;
  localparam logic [31:0] OFF_OUT   = 32'h04;
  localparam logic [31:0] OFF_DIR   = 32'h08;
  localparam logic [31:0] OFF_IMASK = 32'h0C;

  // Read-modify-write alias windows; the register offset is added on top.
  localparam logic [31:0] OFF_OR  = 32'h50;
  localparam logic [31:0] OFF_AND = 32'h60;
  localparam logic [31:0] OFF_XOR = 32'h70;

  // DATA reflects the input pins, so only READ may target it; opcodes above
  // XOR are undefined.
  function automatic logic cmd_illegal(input logic [2:0] op, input logic [1:0] sel);
    logic bad_op;
    bad_op = (op > OP_XOR);
    return bad_op || ((op != OP_READ) && (sel == SEL_DATA));
  endfunction

  // Offset of the APB access for a command, relative to the slave base.
  function automatic logic [31:0] cmd_offset(input logic [2:0] op, input logic [1:0] sel);
    logic [31:0] reg_off;
    logic [31:0] result;
    case (sel)
      SEL_DATA:  reg_off = OFF_DATA;
      SEL_OUT:   reg_off = OFF_OUT;
      SEL_DIR:   reg_off = OFF_DIR;
      default:   reg_off = OFF_IMASK;
    endcase
    case (op)
      OP_OR:   result = OFF_OR + reg_off;
      OP_AND:  result = OFF_AND + reg_off;
      OP_XOR:  result = OFF_XOR + reg_off;
      default: result = reg_off;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/gpio_cmd_arbiter_rr_arbiter.sv
// Round-robin selector: picks the asserted request nearest after 'last',
// wrapping around, and reports it as a one-hot grant.
module rr_arbiter
  import gpio_cmd_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = ID_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // Two passes: first the indices above 'last', then wrap to 0..last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!valid && (i > int'(last)) && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!valid && (i <= int'(last)) && req[i]) begin
        grant[i] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_cmd_arbiter.sv
// Arbitrates GPIO commands from several requesters onto one APB master port.
// One command is in flight at a time; illegal commands are answered with an
// error response without touching the bus.
//
// state  | meaning
// IDLE   | waiting for a request; grant and capture the command
// SETUP  | APB setup phase (psel=1, penable=0), exactly one cycle
// ACCESS | APB access phase (psel=1, penable=1) until pready
// RESP   | one-cycle response strobe to the granted requester
module gpio_cmd_arbiter
  import gpio_cmd_pkg::*;
#(
  parameter int          NREQ = 2,
  parameter logic [31:0] BASE = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [2*NREQ-1:0]    req_sel,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic                 resp_valid,
  output logic [2:0]           resp_id,
  output logic                 resp_err,
  output logic [31:0]          resp_rdata,
  output logic                 apb_psel,
  output logic                 apb_penable,
  output logic                 apb_pwrite,
  output logic [31:0]          apb_paddr,
  output logic [31:0]          apb_pwdata,
  input  logic [31:0]          apb_prdata,
  input  logic                 apb_pready
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [2:0]        op_q, op_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [NREQ-1:0]   arb_grant;
  logic              arb_valid;

  logic [ID_W-1:0]   gnt_idx;
  logic [2:0]        gnt_op;
  logic [1:0]        gnt_sel;
  logic [31:0]       gnt_wdata;

  rr_arbiter #(
    .N  (NREQ),
    .IW (ID_W)
  ) u_rr (
    .req   (req_valid),
    .last  (last_q),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  // Select the winning requester's index and command fields.
  always_comb begin
    gnt_idx   = '0;
    gnt_op    = '0;
    gnt_sel   = '0;
    gnt_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_grant[i]) begin
        gnt_idx   = ID_W'(i);
        gnt_op    = req_op[3*i +: 3];
        gnt_sel   = req_sel[2*i +: 2];
        gnt_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  // Next-state logic, command capture and grant strobe.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    op_d      = op_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = '0;
    case (state_q)
      ST_IDLE: begin
        // Gating with rst keeps req_ready low while the block is held in reset.
        if (arb_valid && !rst) begin
          req_ready = arb_grant;
          last_d    = gnt_idx;
          id_d      = gnt_idx;
          op_d      = gnt_op;
          err_d     = cmd_illegal(gnt_op, gnt_sel);
          addr_d    = BASE + cmd_offset(gnt_op, gnt_sel);
          wdata_d   = gnt_wdata;
          rdata_d   = '0;
          state_d   = err_d ? ST_RESP : ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready) begin
          if (op_q == OP_READ) begin
            rdata_d = apb_prdata;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and captured-command registers; reset aborts any transfer at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= ID_W'(NREQ - 1);
      id_q    <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      op_q    <= op_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // APB drive decoded from state; bus fields are forced to zero when not selected.
  always_comb begin
    apb_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    apb_penable = (state_q == ST_ACCESS);
    apb_pwrite  = apb_psel && (op_q != OP_READ);
    apb_paddr   = apb_psel ? addr_q : '0;
    apb_pwdata  = apb_psel ? wdata_q : '0;
  end

  // Response fields are only non-zero during the one-cycle RESP strobe.
  always_comb begin
    resp_valid = (state_q == ST_RESP);
    resp_id    = resp_valid ? id_q : '0;
    resp_err   = resp_valid && err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_gpio_cmd_arbiter.sv
// Scoreboard bench for gpio_cmd_arbiter with a small GPIO APB slave model.
module tb_gpio_cmd_arbiter;

  localparam int NREQ = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [3*NREQ-1:0]   req_op;
  logic [2*NREQ-1:0]   req_sel;
  logic [32*NREQ-1:0]  req_wdata;
  logic                resp_valid;
  logic [2:0]          resp_id;
  logic                resp_err;
  logic [31:0]         resp_rdata;
  logic                apb_psel, apb_penable, apb_pwrite;
  logic [31:0]         apb_paddr, apb_pwdata;
  logic [31:0]         apb_prdata = '0;
  logic                apb_pready = 1'b0;

  gpio_cmd_arbiter #(.NREQ(NREQ), .BASE(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_sel(req_sel), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata),
    .apb_prdata(apb_prdata), .apb_pready(apb_pready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected transaction, pushed by the stimulus in expected grant order.
  typedef struct {
    int          id;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  // GPIO slave model: OUT/DIR/IMASK registers, DATA reads return gpio_in.
  logic [31:0] s_out = '0, s_dir = '0, s_imask = '0;
  logic [31:0] gpio_in = 32'hA5;
  int wait_n = 0;
  int acc_n  = 0;

  function automatic logic [31:0] alu(input logic [31:0] old, input logic [3:0] kind, input logic [31:0] wd);
    case (kind)
      4'h5:    return old | wd;
      4'h6:    return old & wd;
      4'h7:    return old ^ wd;
      default: return wd;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst || !(apb_psel && apb_penable)) begin
      apb_pready = 1'b0;
      acc_n = 0;
    end else begin
      if (acc_n >= wait_n) begin
        apb_pready = 1'b1;
        if (apb_pwrite) begin
          case (apb_paddr[3:2])
            2'd1: s_out   = alu(s_out, apb_paddr[7:4], apb_pwdata);
            2'd2: s_dir   = alu(s_dir, apb_paddr[7:4], apb_pwdata);
            2'd3: s_imask = alu(s_imask, apb_paddr[7:4], apb_pwdata);
            default: ;
          endcase
        end else begin
          case (apb_paddr[3:2])
            2'd0: apb_prdata = gpio_in;
            2'd1: apb_prdata = s_out;
            2'd2: apb_prdata = s_dir;
            default: apb_prdata = s_imask;
          endcase
        end
      end else begin
        apb_pready = 1'b0;
      end
      acc_n++;
    end
  end

  // Monitor: checks grants, APB phases and responses against the queue front.
  int cyc = 0;
  int grant_cyc = 0;
  logic [31:0] l_addr = '0, l_wdata = '0;
  logic l_wr = 1'b0;
  exp_t m_e;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (req_ready != '0) begin
        if (exp_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 32'h0);
        else chk("grant_id", 32'(req_ready), 32'(1) << exp_q[0].id);
        grant_cyc = cyc;
      end
      if (apb_psel && !apb_penable) begin
        if (exp_q.size() == 0) chk("unexpected_setup", 32'(apb_psel), 32'h0);
        else begin
          chk("setup_on_illegal", 32'(exp_q[0].err), 32'h0);
          chk("setup_paddr", apb_paddr, exp_q[0].addr);
          chk("setup_pwrite", 32'(apb_pwrite), 32'(exp_q[0].wr));
          chk("setup_pwdata", apb_pwdata, exp_q[0].wdata);
          chk("setup_timing", 32'(cyc - grant_cyc), 32'd1);
        end
        l_addr  = apb_paddr;
        l_wdata = apb_pwdata;
        l_wr    = apb_pwrite;
      end else if (apb_psel && apb_penable) begin
        chk("access_stable", {apb_paddr ^ l_addr} | {apb_pwdata ^ l_wdata} | 32'(apb_pwrite ^ l_wr), 32'h0);
      end else begin
        chk("apb_idle_zero", apb_paddr | apb_pwdata | 32'(apb_penable), 32'h0);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'(resp_valid), 32'h0);
        else begin
          m_e = exp_q.pop_front();
          chk("resp_id", 32'(resp_id), 32'(m_e.id));
          chk("resp_err", 32'(resp_err), 32'(m_e.err));
          chk("resp_rdata", resp_rdata, m_e.rdata);
          chk("resp_latency", 32'(cyc - grant_cyc), 32'(m_e.lat));
        end
      end else begin
        chk("resp_idle_zero", resp_rdata | 32'(resp_id) | 32'(resp_err), 32'h0);
      end
    end
  end

  task automatic set_cmd(input int id, input logic [2:0] op, input logic [1:0] sel, input logic [31:0] wd);
    req_op[3*id +: 3]     = op;
    req_sel[2*id +: 2]    = sel;
    req_wdata[32*id +: 32] = wd;
  endtask

  task automatic push(input int id, input logic err, input logic [31:0] rdata, input logic [31:0] addr,
                      input logic wr, input logic [31:0] wd, input int lat);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rdata; e.addr = addr; e.wr = wr; e.wdata = wd; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input int id);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (req_ready[id]) seen = 1'b1;
    end
    chk("grant_seen", 32'(seen), 32'h1);
  endtask

  task automatic issue(input int id, input logic [2:0] op, input logic [1:0] sel, input logic [31:0] wd);
    set_cmd(id, op, sel, wd);
    req_valid[id] = 1'b1;
    wait_grant(id);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(exp_q.size()), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int nresp;
    bit seen;
    rst = 1'b1;
    req_valid = '0;
    req_op = '0;
    req_sel = '0;
    req_wdata = '0;
    set_cmd(0, 3'd0, 2'd1, 32'h1);
    set_cmd(1, 3'd0, 2'd1, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    // Reset state: no grant even with requests pending, bus and response idle.
    req_valid = 2'b11;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_apb_ctl", 32'({apb_psel, apb_penable, apb_pwrite}), 32'h0);
    chk("rst_apb_bus", apb_paddr | apb_pwdata, 32'h0);
    chk("rst_resp", 32'({resp_valid, resp_err, resp_id}) | resp_rdata, 32'h0);
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // GPIO sequence: WRITE OUT 0x35, OR OUT 0x03, WRITE DIR 0xFF, READ OUT.
    push(0, 1'b0, 32'h0, 32'h04, 1'b1, 32'h35, 3);
    issue(0, 3'd0, 2'd1, 32'h35);
    wait_idle();
    push(0, 1'b0, 32'h0, 32'h54, 1'b1, 32'h03, 3);
    issue(0, 3'd2, 2'd1, 32'h03);
    wait_idle();
    push(0, 1'b0, 32'h0, 32'h08, 1'b1, 32'hFF, 3);
    issue(0, 3'd0, 2'd2, 32'hFF);
    wait_idle();
    push(0, 1'b0, 32'h37, 32'h04, 1'b0, 32'h0, 3);
    issue(0, 3'd1, 2'd1, 32'h0);
    wait_idle();
    chk("gpio_dout", {24'h0, s_out[7:0]}, 32'h37);
    chk("gpio_dir", s_dir, 32'hFF);

    // READ DATA with four wait states: ACCESS held five cycles.
    wait_n = 4;
    push(1, 1'b0, 32'hA5, 32'h00, 1'b0, 32'h0, 7);
    issue(1, 3'd1, 2'd0, 32'h0);
    wait_idle();
    wait_n = 0;

    // Illegal commands: XOR DATA, WRITE DATA, undefined opcode.
    push(0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1);
    issue(0, 3'd4, 2'd0, 32'h12);
    wait_idle();
    push(0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1);
    issue(0, 3'd0, 2'd0, 32'h99);
    wait_idle();
    push(1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0, 1);
    issue(1, 3'd5, 2'd1, 32'h0);
    wait_idle();

    // Both requesters continuously valid: grants alternate 0,1,0,1.
    set_cmd(0, 3'd2, 2'd2, 32'h01);
    set_cmd(1, 3'd3, 2'd1, 32'h03);
    for (int r = 0; r < 2; r++) begin
      push(0, 1'b0, 32'h0, 32'h58, 1'b1, 32'h01, 3);
      push(1, 1'b0, 32'h0, 32'h64, 1'b1, 32'h03, 3);
    end
    req_valid = 2'b11;
    grants = 0;
    for (int k = 0; k < 100 && grants < 4; k++) begin
      @(negedge clk);
      if (req_ready != '0) grants++;
    end
    chk("rr_grants", 32'(grants), 32'd4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    chk("gpio_out_after_and", s_out, 32'h03);

    // Reset during ACCESS: bus drops at once, no response follows.
    wait_n = 10;
    push(0, 1'b0, 32'h0, 32'h0C, 1'b1, 32'h0F, 3);
    issue(0, 3'd0, 2'd3, 32'h0F);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (apb_penable) seen = 1'b1;
    end
    chk("access_seen", 32'(seen), 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("abort_psel_penable", 32'({apb_psel, apb_penable}), 32'h0);
    exp_q.delete();
    wait_n = 0;
    nresp = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    chk("abort_no_resp", 32'(nresp), 32'h0);
    chk("abort_no_write", s_imask, 32'h0);
    @(posedge clk); #1;

    // After reset requester 0 wins first although it was the last grantee.
    set_cmd(0, 3'd0, 2'd1, 32'h11);
    set_cmd(1, 3'd0, 2'd2, 32'h22);
    push(0, 1'b0, 32'h0, 32'h04, 1'b1, 32'h11, 3);
    push(1, 1'b0, 32'h0, 32'h08, 1'b1, 32'h22, 3);
    req_valid = 2'b11;
    wait_grant(0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_grant(1);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
